reg_file_checker: RTL

//  Passive checker on the reg_file port, the receiving end of the stimulus that drives that port.

---
 rtl/reg_file_checker_pkg.sv | 18 +
 rtl/reg_file_shadow.sv | 57 +++++
 rtl/reg_file_checker.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/reg_file_checker_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_checker_pkg
// Shared definitions for the reg_file checker: the default register-file
// geometry (kept identical to reg_file) and the checker FSM state encoding,
// which is also exported on the debug "state" port.
// -----------------------------------------------------------------------------
package reg_file_checker_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2
    } chk_state_e;

endpackage

// File: rtl/reg_file_shadow.sv
// -----------------------------------------------------------------------------
// reg_file_shadow
// Shadow copy of the snooped reg_file contents plus one valid bit per register.
// Register 0 is hard-wired: it always reads as a valid zero and ignores writes.
//
// Ports
//   clk       in   clock, writes land on posedge
//   i_rst_n   in   synchronous active-low reset, clears data and valid bits
//   i_wen     in   write enable
//   i_waddr   in   write address
//   i_wdata   in   write data
//   i_raddr1  in   read address, port 1
//   i_raddr2  in   read address, port 2
//   o_rd1     out  {valid, data} for port 1 (combinational, pre-edge value)
//   o_rd2     out  {valid, data} for port 2 (combinational, pre-edge value)
// -----------------------------------------------------------------------------
module reg_file_shadow
    import reg_file_checker_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_wen,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr1,
    input  logic [ADDR_WIDTH-1:0] i_raddr2,
    output logic [DATA_WIDTH:0]   o_rd1,
    output logic [DATA_WIDTH:0]   o_rd2
);

    localparam int NREG = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_data [NREG];
    logic [NREG-1:0]       r_valid;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_data[i] <= '0;
            end
            r_valid <= '0;
        end else if (i_wen && (i_waddr != '0)) begin
            r_data[i_waddr]  <= i_wdata;
            r_valid[i_waddr] <= 1'b1;
        end
    end

    // Reg 0 reads a valid zero regardless of storage contents.
    assign o_rd1 = (i_raddr1 == '0) ? {1'b1, {DATA_WIDTH{1'b0}}}
                                    : {r_valid[i_raddr1], r_data[i_raddr1]};
    assign o_rd2 = (i_raddr2 == '0) ? {1'b1, {DATA_WIDTH{1'b0}}}
                                    : {r_valid[i_raddr2], r_data[i_raddr2]};

endmodule

// File: rtl/reg_file_checker.sv
// -----------------------------------------------------------------------------
// reg_file_checker
// Passive checker placed beside a reg_file. It snoops write traffic into a
// shadow copy and compares every enabled read against it. Reports a sticky
// error flag, a saturating mismatch count and details of the first failure.
//
// Ports
//   clk       in   single clock
//   rst       in   synchronous active-low reset
//   chk_en    in   1 = compare reads, 0 = only track writes
//   wen       in   snooped write enable
//   waddr     in   snooped write address
//   wdata     in   snooped write data
//   raddr1    in   snooped read address, port 1
//   rdata1    in   snooped read data, port 1
//   raddr2    in   snooped read address, port 2
//   rdata2    in   snooped read data, port 2
//   err       out  sticky mismatch flag
//   err_cnt   out  saturating mismatch count (0..2 added per cycle)
//   err_port  out  first failure: bit0 = port1 failed, bit1 = port2 failed
//   err_addr  out  first failure address (port1 wins if both failed)
//   err_exp   out  first failure expected (shadow) value
//   err_got   out  first failure observed read data
//   state     out  FSM state for debug (IDLE/RUN/FAIL)
// -----------------------------------------------------------------------------
module reg_file_checker
    import reg_file_checker_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chk_en,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [DATA_WIDTH-1:0] rdata1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    input  logic [DATA_WIDTH-1:0] rdata2,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [1:0]            err_port,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [DATA_WIDTH-1:0] err_exp,
    output logic [DATA_WIDTH-1:0] err_got,
    output logic [1:0]            state
);

    chk_state_e            r_state;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [1:0]            r_port;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_exp;
    logic [DATA_WIDTH-1:0] r_got;

    logic [DATA_WIDTH:0]   w_rd1;
    logic [DATA_WIDTH:0]   w_rd2;
    logic                  w_cmp_on;
    logic                  w_mis1;
    logic                  w_mis2;
    logic                  w_any;
    logic [1:0]            w_inc;

    // Adds 0..2 to the counter and clamps at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [1:0]           inc);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, inc};
        return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    endfunction

    reg_file_shadow #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_shadow (
        .clk      (clk),
        .i_rst_n  (rst),
        .i_wen    (wen),
        .i_waddr  (waddr),
        .i_wdata  (wdata),
        .i_raddr1 (raddr1),
        .i_raddr2 (raddr2),
        .o_rd1    (w_rd1),
        .o_rd2    (w_rd2)
    );

    // Shadow reads give the pre-edge value, so a same-cycle write to the read
    // address is compared against the old contents. Unwritten registers are
    // skipped. Case inequality makes X/Z on the snooped data a mismatch.
    assign w_cmp_on = (r_state != ST_IDLE) && chk_en;
    assign w_mis1   = w_cmp_on && w_rd1[DATA_WIDTH] && (rdata1 !== w_rd1[DATA_WIDTH-1:0]);
    assign w_mis2   = w_cmp_on && w_rd2[DATA_WIDTH] && (rdata2 !== w_rd2[DATA_WIDTH-1:0]);
    assign w_any    = w_mis1 || w_mis2;
    assign w_inc    = {1'b0, w_mis1} + {1'b0, w_mis2};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_port  <= '0;
            r_addr  <= '0;
            r_exp   <= '0;
            r_got   <= '0;
        end else begin
            // Counting continues in FAIL for as long as compares are enabled.
            if (w_any) begin
                r_err <= 1'b1;
                r_cnt <= sat_add(r_cnt, w_inc);
            end
            case (r_state)
                ST_IDLE: begin
                    if (chk_en) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_any) begin
                        // First failure: capture once, port1 has priority.
                        r_state <= ST_FAIL;
                        r_port  <= {w_mis2, w_mis1};
                        r_addr  <= w_mis1 ? raddr1 : raddr2;
                        r_exp   <= w_mis1 ? w_rd1[DATA_WIDTH-1:0] : w_rd2[DATA_WIDTH-1:0];
                        r_got   <= w_mis1 ? rdata1 : rdata2;
                    end else if (!chk_en) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FAIL: begin
                    r_state <= ST_FAIL;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign err      = r_err;
    assign err_cnt  = r_cnt;
    assign err_port = r_port;
    assign err_addr = r_addr;
    assign err_exp  = r_exp;
    assign err_got  = r_got;
    assign state    = r_state;

endmodule
